// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter with IDLE/BUSY/GAP FSM and registered bus request
//   params : ROUND_ROBIN  1 = alternate on contention, 0 = requester 1 always wins
//   clock  : clk, async active-low reset rst_n
//   req0/1 : rN_read, rN_write, rN_addr, rN_io, rN_wdata in; rN_rdata, rN_done out
//   bus    : memory_read/write/addr/io/wdata out (registered); memory_rdata, memory_done in
//   status : grant (owner of current/last transaction), busy (state is BUSY)
module mem_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [15:0] r0_addr,
  input  logic        r0_io,
  input  logic [7:0]  r0_wdata,
  output logic [7:0]  r0_rdata,
  output logic        r0_done,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [15:0] r1_addr,
  input  logic        r1_io,
  input  logic [7:0]  r1_wdata,
  output logic [7:0]  r1_rdata,
  output logic        r1_done,
  output logic        memory_read,
  output logic        memory_write,
  output logic [15:0] memory_addr,
  output logic        memory_io,
  output logic [7:0]  memory_wdata,
  input  logic [7:0]  memory_rdata,
  input  logic        memory_done,
  output logic        grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state, state_nx;
  logic pend0, pend1, win, take;
  assign pend0 = r0_read | r0_write;
  assign pend1 = r1_read | r1_write;
  // on contention, round robin hands the bus to whoever did not own it last
  assign win = (pend0 & pend1) ? ((ROUND_ROBIN != 0) ? ~grant : 1'b1) : pend1;
  assign take = (state == IDLE) & (pend0 | pend1);
  assign busy = state == BUSY;
  assign r0_done = memory_done & busy & ~grant;
  assign r1_done = memory_done & busy & grant;
  assign r0_rdata = memory_rdata;
  assign r1_rdata = memory_rdata;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? BUSY : IDLE;
      BUSY:    state_nx = memory_done ? GAP : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= 1'b0;
      memory_read  <= 1'b0;
      memory_write <= 1'b0;
      memory_addr  <= '0;
      memory_io    <= 1'b0;
      memory_wdata <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        grant        <= win;
        memory_addr  <= win ? r1_addr : r0_addr;
        memory_io    <= win ? r1_io : r0_io;
        memory_wdata <= win ? r1_wdata : r0_wdata;
        // read+write together is treated as a write
        memory_write <= win ? r1_write : r0_write;
        memory_read  <= win ? (r1_read & ~r1_write) : (r0_read & ~r0_write);
      end else if (busy && memory_done) begin
        memory_read  <= 1'b0;
        memory_write <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (round-robin and fixed-priority instances)
module tb_mem_arbiter;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_read = 0, r0_write = 0, r0_io = 0, r1_read = 0, r1_write = 0, r1_io = 0;
  logic [15:0] r0_addr = '0, r1_addr = '0;
  logic [7:0] r0_wdata = '0, r1_wdata = '0, mem_rdata = 8'hA5;
  logic stray = 1'b0;
  logic [7:0] a_r0_rdata, a_r1_rdata, a_wdata, b_r0_rdata, b_r1_rdata, b_wdata;
  logic a_r0_done, a_r1_done, a_read, a_write, a_io, a_grant, a_busy, a_mdone;
  logic b_r0_done, b_r1_done, b_read, b_write, b_io, b_grant, b_busy, b_mdone;
  logic [15:0] a_addr, b_addr;
  int a_cnt = 0, b_cnt = 0;
  int errors = 0, checks = 0;
  int who;

  always #5 clk = ~clk;

  // bus model: done in the LAT-th BUSY cycle, plus an optional stray pulse
  always @(posedge clk) begin
    a_cnt <= a_busy ? a_cnt + 1 : 0;
    b_cnt <= b_busy ? b_cnt + 1 : 0;
  end
  assign a_mdone = (a_busy && a_cnt == LAT - 1) | stray;
  assign b_mdone = (b_busy && b_cnt == LAT - 1) | stray;

  mem_arbiter #(.ROUND_ROBIN(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_io(r0_io), .r0_wdata(r0_wdata),
    .r0_rdata(a_r0_rdata), .r0_done(a_r0_done),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_io(r1_io), .r1_wdata(r1_wdata),
    .r1_rdata(a_r1_rdata), .r1_done(a_r1_done),
    .memory_read(a_read), .memory_write(a_write), .memory_addr(a_addr), .memory_io(a_io),
    .memory_wdata(a_wdata), .memory_rdata(mem_rdata), .memory_done(a_mdone),
    .grant(a_grant), .busy(a_busy));

  mem_arbiter #(.ROUND_ROBIN(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_io(r0_io), .r0_wdata(r0_wdata),
    .r0_rdata(b_r0_rdata), .r0_done(b_r0_done),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_io(r1_io), .r1_wdata(r1_wdata),
    .r1_rdata(b_r1_rdata), .r1_done(b_r1_done),
    .memory_read(b_read), .memory_write(b_write), .memory_addr(b_addr), .memory_io(b_io),
    .memory_wdata(b_wdata), .memory_rdata(mem_rdata), .memory_done(b_mdone),
    .grant(b_grant), .busy(b_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    {r0_read, r0_write, r1_read, r1_write, r0_io, r1_io, stray} = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // waits (bounded) for a done pulse on the selected instance; returns the served requester
  task automatic serve(input bit sel, output int w);
    logic d0, d1;
    w = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d0 = sel ? b_r0_done : a_r0_done;
      d1 = sel ? b_r1_done : a_r1_done;
      if (d0 | d1) begin
        w = d1 ? 1 : 0;
        check("one_done", {30'd0, d0, d1} == 2'b11, 0);
        break;
      end
    end
    if (w < 0) check("done_timeout", 1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_grant", a_grant, 0);
    check("rst_rw", {a_read, a_write}, 0);
    check("rst_addr", a_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read from requester 0 with fixed bus latency
    r0_read = 1; r0_addr = 16'h1234; r0_io = 0;
    @(negedge clk);
    check("rd_busy", a_busy, 1);
    check("rd_memread", {a_read, a_write}, 2'b10);
    check("rd_addr", a_addr, 16'h1234);
    check("rd_nodone", a_r0_done, 0);
    @(negedge clk);
    check("rd_nodone2", a_r0_done, 0);
    @(negedge clk);
    check("rd_done", {a_r0_done, a_r1_done}, 2'b10);
    check("rd_rdata", a_r0_rdata, 8'hA5);
    r0_read = 0;
    @(negedge clk);
    check("rd_gap_busy", a_busy, 0);
    check("rd_gap_read", a_read, 0);
    check("rd_gap_done", a_r0_done, 0);

    // contention with round robin: r1, r0, r1, r0 with one GAP between
    do_reset();
    r0_write = 1; r0_addr = 16'h0010; r0_wdata = 8'h11;
    r1_write = 1; r1_addr = 16'h0020; r1_wdata = 8'h22;
    serve(0, who); check("rr_1", who, 1); check("rr_1_addr", a_addr, 16'h0020); check("rr_1_data", a_wdata, 8'h22);
    @(negedge clk); check("rr_gap", a_busy, 0);
    @(negedge clk); check("rr_idle", a_busy, 0);
    @(negedge clk); check("rr_next_busy", a_busy, 1);
    serve(0, who); check("rr_2", who, 0); check("rr_2_addr", a_addr, 16'h0010); check("rr_2_data", a_wdata, 8'h11);
    serve(0, who); check("rr_3", who, 1);
    serve(0, who); check("rr_4", who, 0);

    // contention with fixed priority: r1 always, r0 only once r1 drops
    do_reset();
    r0_write = 1; r1_write = 1;
    serve(1, who); check("fp_1", who, 1);
    serve(1, who); check("fp_2", who, 1);
    serve(1, who); check("fp_3", who, 1);
    r1_write = 0;
    serve(1, who); check("fp_4", who, 0);
    check("fp_4_addr", b_addr, 16'h0010);

    // inputs changing during BUSY are ignored
    do_reset();
    r0_write = 1; r0_addr = 16'h0010; r1_addr = 16'h0020;
    @(negedge clk);
    check("hold_busy", a_busy, 1);
    r0_addr = 16'hFFFF; r1_write = 1;
    @(negedge clk);
    check("hold_addr", a_addr, 16'h0010);
    check("hold_grant", a_grant, 0);
    serve(0, who); check("hold_who", who, 0);
    r0_write = 0;
    @(negedge clk);
    check("hold_gap_busy", a_busy, 0);
    check("hold_gap_grant", a_grant, 0);
    serve(0, who); check("hold_r1", who, 1); check("hold_r1_addr", a_addr, 16'h0020);
    r1_write = 0;

    // async reset mid-transaction, then stray done
    do_reset();
    r1_write = 1; r1_addr = 16'h0020;
    @(negedge clk);
    check("ar_pre", {a_busy, a_write, a_grant}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check("ar_write", a_write, 0);
    check("ar_busy", a_busy, 0);
    check("ar_grant", a_grant, 0);
    check("ar_addr", a_addr, 0);
    r1_write = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray = 1;
    #1;
    check("stray_done", {a_r0_done, a_r1_done}, 0);
    @(negedge clk);
    stray = 0;
    check("stray_busy", a_busy, 0);

    // read and write together latched as a write
    do_reset();
    r1_read = 1; r1_write = 1; r1_addr = 16'h0042; r1_wdata = 8'h5A;
    @(negedge clk);
    check("rw_flags", {a_read, a_write}, 2'b01);
    check("rw_wdata", a_wdata, 8'h5A);
    check("rw_addr", a_addr, 16'h0042);
    serve(0, who); check("rw_who", who, 1);
    r1_read = 0; r1_write = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
